// File: rtl/seg_scan_mux.sv
// rtl/seg_scan_mux.sv - time-multiplexed N-digit 7-segment scanner with tear-free shadow display
module seg_scan_mux #(
  parameter int NUM_DIGITS     = 4,
  parameter int DIV_WIDTH      = 16,
  parameter int DIV_MAX        = 49999,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] bcd_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    blank_zero,
  input  logic                    hex_mode,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [6:0] SEG_OFF = SEG_ACTIVE_LOW ? 7'h7f : 7'h00;
  localparam logic DP_OFF = SEG_ACTIVE_LOW;
  localparam logic [NUM_DIGITS-1:0] AN_OFF = AN_ACTIVE_LOW ? '1 : '0;

  logic [DIV_WIDTH-1:0]    cnt;
  logic [IDX_W-1:0]        idx;
  logic [4*NUM_DIGITS-1:0] pend_bcd, disp_bcd;
  logic [NUM_DIGITS-1:0]   pend_dp, disp_dp;
  logic                    pend_valid;
  logic                    tick, last, boundary;
  logic [3:0]              cur_digit;
  logic                    cur_dp, upper_zero;
  logic [NUM_DIGITS-1:0]   an_onehot;
  logic [6:0]              seg_lit;

  function automatic logic [6:0] decode(input logic [3:0] code, input logic hex);
    logic [6:0] s;
    case (code)
      4'd0:    s = 7'b1111110;
      4'd1:    s = 7'b0110000;
      4'd2:    s = 7'b1101101;
      4'd3:    s = 7'b1111001;
      4'd4:    s = 7'b0110011;
      4'd5:    s = 7'b1011011;
      4'd6:    s = 7'b1011111;
      4'd7:    s = 7'b1110000;
      4'd8:    s = 7'b1111111;
      4'd9:    s = 7'b1111011;
      4'd10:   s = 7'b1110111;
      4'd11:   s = 7'b0011111;
      4'd12:   s = 7'b1001110;
      4'd13:   s = 7'b0111101;
      4'd14:   s = 7'b1001111;
      default: s = 7'b1000111;
    endcase
    if (!hex && code > 4'd9) s = 7'b0000000;
    return s;
  endfunction

  assign tick     = (cnt == DIV_WIDTH'(DIV_MAX));
  assign last     = (idx == IDX_W'(NUM_DIGITS - 1));
  assign boundary = tick && last;

  // upper_zero: every digit from idx up to the most significant one is zero
  always_comb begin
    cur_digit  = 4'd0;
    cur_dp     = 1'b0;
    an_onehot  = '0;
    upper_zero = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        cur_digit    = disp_bcd[i*4 +: 4];
        cur_dp       = disp_dp[i];
        an_onehot[i] = 1'b1;
      end
      if (i >= int'(idx) && disp_bcd[i*4 +: 4] != 4'd0) upper_zero = 1'b0;
    end
    seg_lit = (blank_zero && upper_zero && idx != '0) ? 7'b0000000
                                                      : decode(cur_digit, hex_mode);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      idx        <= '0;
      pend_bcd   <= '0;
      pend_dp    <= '0;
      pend_valid <= 1'b0;
      disp_bcd   <= '0;
      disp_dp    <= '0;
      seg        <= SEG_OFF;
      dp         <= DP_OFF;
      an         <= AN_OFF;
      frame_done <= 1'b0;
    end else begin
      cnt        <= tick ? '0 : cnt + 1'b1;
      frame_done <= boundary;
      if (tick) idx <= last ? '0 : idx + 1'b1;
      if (load) begin
        pend_bcd <= bcd_in;
        pend_dp  <= dp_in;
      end
      // a load on the boundary cycle keeps pending_valid set for the next frame
      pend_valid <= load | (pend_valid & ~boundary);
      if (boundary && pend_valid) begin
        disp_bcd <= pend_bcd;
        disp_dp  <= pend_dp;
      end
      // blank everything for one cycle after each tick so anodes never ghost
      if (tick) begin
        seg <= SEG_OFF;
        dp  <= DP_OFF;
        an  <= AN_OFF;
      end else begin
        seg <= SEG_ACTIVE_LOW ? ~seg_lit : seg_lit;
        dp  <= SEG_ACTIVE_LOW ? ~cur_dp : cur_dp;
        an  <= AN_ACTIVE_LOW ? ~an_onehot : an_onehot;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_mux.sv
// tb/tb_seg_scan_mux.sv - directed table-driven bench for seg_scan_mux
module tb_seg_scan_mux;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load;
  logic [15:0] bcd_in;
  logic [3:0]  dp_in;
  logic        blank_zero;
  logic        hex_mode;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame_done;

  int total = 0;
  int bad   = 0;

  seg_scan_mux #(
    .NUM_DIGITS(4), .DIV_WIDTH(16), .DIV_MAX(3),
    .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .bcd_in(bcd_in), .dp_in(dp_in),
    .blank_zero(blank_zero), .hex_mode(hex_mode), .seg(seg), .dp(dp),
    .an(an), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // active-low segment patterns, ABCDEFG
  localparam logic [6:0] S0 = 7'b0000001, S1 = 7'b1001111, S2 = 7'b0010010;
  localparam logic [6:0] S3 = 7'b0000110, S4 = 7'b1001100, S5 = 7'b0100100;
  localparam logic [6:0] S9 = 7'b0000100, SA = 7'b0001000, SB = 7'b1100000;
  localparam logic [6:0] SC = 7'b0110001, SD = 7'b1000010, SX = 7'b1111111;

  typedef struct {
    logic [15:0] bcd;
    logic [3:0]  dpi;
    logic        bz;
    logic        hex;
    logic [27:0] segs;
    logic [3:0]  dps;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic load_data(input logic [15:0] b, input logic [3:0] d);
    bcd_in = b;
    dp_in  = d;
    load   = 1'b1;
    @(negedge clk);
    load   = 1'b0;
  endtask

  task automatic wait_frame(input bit chk_old, input logic [6:0] old_seg);
    bit found = 0;
    int n = 0;
    while (!found && n < 40) begin
      @(negedge clk);
      n++;
      if (frame_done) found = 1;
      else if (chk_old && an != 4'hf) chk("hold_seg", {25'd0, seg}, {25'd0, old_seg});
    end
    if (!found) chk("frame_timeout", 32'd0, 32'd1);
  endtask

  // called on the frame_done cycle; walks one whole frame
  task automatic check_frame(input string tag, input logic [27:0] segs, input logic [3:0] dps);
    logic [3:0] exp_an;
    int d;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (k % 4 != 0) begin
        d = (k - 1) / 4;
        exp_an = ~(4'b0001 << d);
        chk($sformatf("%s_an_d%0d", tag, d), {28'd0, an}, {28'd0, exp_an});
        chk($sformatf("%s_seg_d%0d", tag, d), {25'd0, seg}, {25'd0, segs[d*7 +: 7]});
        chk($sformatf("%s_dp_d%0d", tag, d), {31'd0, dp}, {31'd0, dps[d]});
      end else begin
        chk($sformatf("%s_guard_an", tag), {28'd0, an}, 32'hf);
        chk($sformatf("%s_guard_seg", tag), {25'd0, seg}, 32'h7f);
      end
      chk($sformatf("%s_fdone_%0d", tag, k), {31'd0, frame_done}, (k == 16) ? 32'd1 : 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{16'h1234, 4'b0100, 1'b0, 1'b0, {S1, S2, S3, S4}, 4'b1011};
    vecs[1] = '{16'h0050, 4'b0000, 1'b1, 1'b0, {SX, SX, S5, S0}, 4'b1111};
    vecs[2] = '{16'h0050, 4'b0000, 1'b0, 1'b0, {S0, S0, S5, S0}, 4'b1111};
    vecs[3] = '{16'hABCD, 4'b0000, 1'b0, 1'b1, {SA, SB, SC, SD}, 4'b1111};
    vecs[4] = '{16'hABCD, 4'b0000, 1'b0, 1'b0, {SX, SX, SX, SX}, 4'b1111};
    vecs[5] = '{16'h0000, 4'b1111, 1'b1, 1'b0, {SX, SX, SX, S0}, 4'b0000};
    vecs[6] = '{16'h0900, 4'b0000, 1'b1, 1'b0, {SX, S9, S0, S0}, 4'b1111};

    rst_n = 1'b0; load = 1'b0; bcd_in = '0; dp_in = '0;
    blank_zero = 1'b0; hex_mode = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_an", {28'd0, an}, 32'hf);
    chk("rst_seg", {25'd0, seg}, 32'h7f);
    chk("rst_dp", {31'd0, dp}, 32'd1);
    chk("rst_fdone", {31'd0, frame_done}, 32'd0);
    rst_n = 1'b1;
    check_frame("startup", {S0, S0, S0, S0}, 4'b1111);

    for (int i = 0; i < 7; i++) begin
      blank_zero = vecs[i].bz;
      hex_mode   = vecs[i].hex;
      load_data(vecs[i].bcd, vecs[i].dpi);
      wait_frame(i == 0, S0);
      check_frame($sformatf("v%0d", i), vecs[i].segs, vecs[i].dps);
    end

    // load exactly on the boundary cycle: 1111 commits first, 2222 one frame later
    blank_zero = 1'b0;
    hex_mode   = 1'b0;
    load_data(16'h1111, 4'b0000);
    repeat (14) @(negedge clk);
    load_data(16'h2222, 4'b0000);
    chk("coinc_boundary", {31'd0, frame_done}, 32'd1);
    check_frame("coinc1", {S1, S1, S1, S1}, 4'b1111);
    check_frame("coinc2", {S2, S2, S2, S2}, 4'b1111);

    // reset mid-scan with a pending load outstanding
    load_data(16'h7777, 4'b1111);
    repeat (5) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_an", {28'd0, an}, 32'hf);
    chk("arst_seg", {25'd0, seg}, 32'h7f);
    chk("arst_dp", {31'd0, dp}, 32'd1);
    chk("arst_fdone", {31'd0, frame_done}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    check_frame("restart", {S0, S0, S0, S0}, 4'b1111);
    check_frame("nopend", {S0, S0, S0, S0}, 4'b1111);
    blank_zero = 1'b1;
    check_frame("rst_blank", {SX, SX, SX, S0}, 4'b1111);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
